// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial receive controller.
//
// Contents:
//   DW_DEFAULT / CW_DEFAULT : default widths of the captured word and the timebase counter
//   state_t                 : controller state encoding. DONE is reserved and is never
//                             entered; the controller decodes it back to IDLE.
package serial_rx_pkg;

   localparam int unsigned DW_DEFAULT = 256;
   localparam int unsigned CW_DEFAULT = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/serial_rx.sv
// Serial bit receiver slaved to the controller's timebase.
//
// The frame is a lead-in of n0 cycles followed by nbits bit periods of n1 cycles
// each, MSB first. Each bit is sampled in the middle of its period, at
// cnt == n0 + i*n1 + n1/2. Sampled bits shift in at the LSB, so after the last
// bit the word is right-aligned.
//
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   rx_rst     : synchronous active-high reset from the controller; clears the
//                shift register and reloads the sampling schedule
//   cnt        : controller timebase, 0 on the first receive cycle
//   nbits      : bits per frame (already zero-substituted by the controller)
//   n0, n1     : lead-in length and bit period (already zero-substituted)
//   a          : serial input
//   word       : bits received so far
module serial_rx
   import serial_rx_pkg::*;
#(
   parameter int unsigned P_DW = DW_DEFAULT,
   parameter int unsigned P_CW = CW_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            rx_rst,
   input  logic [P_CW-1:0] cnt,
   input  logic [7:0]      nbits,
   input  logic [P_CW-1:0] n0,
   input  logic [P_CW-1:0] n1,
   input  logic            a,
   output logic [P_DW-1:0] word
);

   // Wide enough that stepping past the last sample point never wraps.
   localparam int unsigned SW = P_CW + 9;

   logic [P_DW-1:0] shift_reg;
   logic [SW-1:0]   next_sample_reg;
   logic [8:0]      taken_reg;
   logic            sample_now;

   assign sample_now = (taken_reg < {1'b0, nbits}) &&
                       ({9'd0, cnt} == next_sample_reg);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_reg       <= '0;
         next_sample_reg <= '0;
         taken_reg       <= '0;
      end else if (rx_rst) begin
         shift_reg       <= '0;
         next_sample_reg <= SW'(n0) + SW'(n1 >> 1);
         taken_reg       <= '0;
      end else if (sample_now) begin
         shift_reg       <= {shift_reg[P_DW-2:0], a};
         next_sample_reg <= next_sample_reg + SW'(n1);
         taken_reg       <= taken_reg + 9'd1;
      end
   end

   assign word = shift_reg;

endmodule

// File: rtl/serial_rx_ctrl.sv
// Serial receive controller: accepts a start request, times one frame with a
// free-running counter, and captures the word assembled by serial_rx into a
// valid/ready output register.
//
// Optional build macro: SERIAL_RX_CTRL_STATS_EN adds the 16-bit frame_cnt output,
// counting every capture (including overruns) and wrapping at 0xFFFF.
//
// Ports:
//   clk, rst_n     : clock and asynchronous active-low reset
//   start          : single-cycle frame request, honoured only while idle
//   nbits, n0, n1  : bits per frame, lead-in cycles, cycles per bit (0 means 1)
//   a              : serial input, MSB first
//   busy           : a frame is in progress
//   data, valid    : captured word (right-aligned) and its valid flag
//   ready          : consumer handshake
//   overrun        : sticky, a frame completed while the previous word was unconsumed
//   cfg_err        : sticky, a start was rejected because the frame length overflows
//   clr            : clears overrun and cfg_err (a simultaneous set wins)
//   frame_cnt      : capture counter (SERIAL_RX_CTRL_STATS_EN builds only)
module serial_rx_ctrl
   import serial_rx_pkg::*;
#(
   parameter int unsigned P_DW = DW_DEFAULT,
   parameter int unsigned P_CW = CW_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [7:0]      nbits,
   input  logic [P_CW-1:0] n0,
   input  logic [P_CW-1:0] n1,
   input  logic            a,
   output logic            busy,
   output logic [P_DW-1:0] data,
   output logic            valid,
   input  logic            ready,
   output logic            overrun,
   output logic            cfg_err,
   input  logic            clr
`ifdef SERIAL_RX_CTRL_STATS_EN
   ,
   output logic [15:0]     frame_cnt
`endif
);

   // n0 + nbits*n1 needs P_CW + 8 bits for the product plus one for the sum.
   localparam int unsigned EW = P_CW + 9;

   state_t          state_reg, state_next;
   logic [P_CW-1:0] cnt_reg;
   logic [P_CW-1:0] n0_reg, n1_reg, end_p1_reg;
   logic [7:0]      nbits_reg;
   logic [P_DW-1:0] data_reg;
   logic            valid_reg, overrun_reg, cfg_err_reg;

   logic [7:0]      nbits_eff;
   logic [P_CW-1:0] n0_eff, n1_eff;
   logic [EW-1:0]   end_calc;
   logic            accept, cfg_bad, start_ok, cfg_set;
   logic            capture, overrun_set, rx_rst;
   logic [P_DW-1:0] rx_word, mask;

   // ------------------------------------------------------------------
   // Start qualification
   // ------------------------------------------------------------------
   assign nbits_eff = (nbits == 8'd0)     ? 8'd1       : nbits;
   assign n0_eff    = (n0 == '0)          ? P_CW'(1)   : n0;
   assign n1_eff    = (n1 == '0)          ? P_CW'(1)   : n1;
   assign end_calc  = EW'(n0_eff) + EW'(nbits_eff) * EW'(n1_eff);

   // The counter must be able to reach end+1 without wrapping, so end+1 may be
   // at most 2^P_CW-1, i.e. end itself at most 2^P_CW-2.
   assign cfg_bad  = (end_calc >= EW'({P_CW{1'b1}}));
   assign accept   = start && (state_reg == ST_IDLE);
   assign start_ok = accept && !cfg_bad;
   assign cfg_set  = accept && cfg_bad;

   assign capture     = (state_reg == ST_RUN) && (cnt_reg == end_p1_reg);
   assign overrun_set = capture && valid_reg && !ready;

   // Receiver is held in reset everywhere except RUN, so ARM is the cycle in
   // which it loads the freshly latched schedule.
   assign rx_rst = (state_reg != ST_RUN);

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (start_ok) state_next = ST_ARM;
         ST_ARM:  state_next = ST_RUN;
         ST_RUN:  if (capture) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Timebase and latched frame parameters
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg    <= '0;
         nbits_reg  <= 8'd1;
         n0_reg     <= P_CW'(1);
         n1_reg     <= P_CW'(1);
         end_p1_reg <= '0;
      end else begin
         if (state_reg == ST_RUN && !capture) begin
            cnt_reg <= cnt_reg + P_CW'(1);
         end else begin
            cnt_reg <= '0;
         end
         if (start_ok) begin
            nbits_reg  <= nbits_eff;
            n0_reg     <= n0_eff;
            n1_reg     <= n1_eff;
            end_p1_reg <= end_calc[P_CW-1:0] + P_CW'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Receiver
   // ------------------------------------------------------------------
   serial_rx #(
      .P_DW (P_DW),
      .P_CW (P_CW)
   ) u_rx (
      .clk    (clk),
      .rst_n  (rst_n),
      .rx_rst (rx_rst),
      .cnt    (cnt_reg),
      .nbits  (nbits_reg),
      .n0     (n0_reg),
      .n1     (n1_reg),
      .a      (a),
      .word   (rx_word)
   );

   // Keep only the low nbits bits of the received word.
   for (genvar gi = 0; gi < P_DW; gi++) begin : g_mask
      assign mask[gi] = (9'(gi) < {1'b0, nbits_reg});
   end

   // ------------------------------------------------------------------
   // Output word, handshake and sticky flags
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_reg    <= '0;
         valid_reg   <= 1'b0;
         overrun_reg <= 1'b0;
         cfg_err_reg <= 1'b0;
      end else begin
         if (capture && (!valid_reg || ready)) begin
            data_reg  <= rx_word & mask;
            valid_reg <= 1'b1;
         end else if (!capture && valid_reg && ready) begin
            valid_reg <= 1'b0;
         end
         // On overrun the old word stays and the new one is dropped.

         if (overrun_set) begin
            overrun_reg <= 1'b1;
         end else if (clr) begin
            overrun_reg <= 1'b0;
         end

         if (cfg_set) begin
            cfg_err_reg <= 1'b1;
         end else if (clr) begin
            cfg_err_reg <= 1'b0;
         end
      end
   end

`ifdef SERIAL_RX_CTRL_STATS_EN
   logic [15:0] frame_cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_reg <= '0;
      end else if (capture) begin
         frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
   end

   assign frame_cnt = frame_cnt_reg;
`else
   // Statistics disabled: this build has no frame counter.
`endif

   assign busy    = (state_reg != ST_IDLE);
   assign data    = data_reg;
   assign valid   = valid_reg;
   assign overrun = overrun_reg;
   assign cfg_err = cfg_err_reg;

endmodule

// File: tb/tb_serial_rx_ctrl.sv
// Self-checking bench for serial_rx_ctrl.
// A frame-level model predicts busy/valid/data/overrun/cfg_err every cycle from
// the frame arithmetic (busy lasts end+3 cycles from the accepting edge, capture
// happens on the edge that ends it); directed frames add literal expectations.
module tb_serial_rx_ctrl;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [7:0]   nbits;
   logic [31:0]  n0;
   logic [31:0]  n1;
   logic         a;
   logic         busy;
   logic [255:0] data;
   logic         valid;
   logic         ready;
   logic         overrun;
   logic         cfg_err;
   logic         clr;
`ifdef SERIAL_RX_CTRL_STATS_EN
   logic [15:0]  frame_cnt;
`endif

   always #5 clk = ~clk;

   serial_rx_ctrl dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .nbits   (nbits),
      .n0      (n0),
      .n1      (n1),
      .a       (a),
      .busy    (busy),
      .data    (data),
      .valid   (valid),
      .ready   (ready),
      .overrun (overrun),
      .cfg_err (cfg_err),
      .clr     (clr)
`ifdef SERIAL_RX_CTRL_STATS_EN
      ,
      .frame_cnt (frame_cnt)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Frame-level model
   // ------------------------------------------------------------------
   logic [255:0] tx_word;          // word the stimulus is about to send
   logic [255:0] m_word, m_data;
   logic [255:0] one256 = 256'd1;
   logic         m_valid, m_ovr, m_cfg, m_cap, m_ov_set, m_cfg_set;
   longint       m_busy_left, m_nb, m_p0, m_p1, m_end;
   logic [15:0]  m_frames;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy_left = 0;
         m_word      = '0;
         m_data      = '0;
         m_valid     = 1'b0;
         m_ovr       = 1'b0;
         m_cfg       = 1'b0;
         m_frames    = '0;
      end else begin
         m_cap     = (m_busy_left == 1);
         m_ov_set  = 1'b0;
         m_cfg_set = 1'b0;
         if (m_cap) begin
            m_frames = m_frames + 16'd1;
            if (!m_valid || ready) begin
               m_data  = m_word;
               m_valid = 1'b1;
            end else begin
               m_ov_set = 1'b1;
            end
         end else if (m_valid && ready) begin
            m_valid = 1'b0;
         end
         if (m_busy_left > 0) begin
            m_busy_left = m_busy_left - 1;
         end else if (start) begin
            m_nb  = (nbits == 0) ? 1 : longint'(nbits);
            m_p0  = (n0 == 0) ? 1 : longint'(n0);
            m_p1  = (n1 == 0) ? 1 : longint'(n1);
            m_end = m_p0 + m_nb * m_p1;
            if (m_end + 1 > 64'h0000_0000_FFFF_FFFF) begin
               m_cfg_set = 1'b1;
            end else begin
               m_busy_left = m_end + 3;
               m_word      = tx_word & ((one256 << m_nb) - one256);
            end
         end
         if (m_ov_set) m_ovr = 1'b1;
         else if (clr) m_ovr = 1'b0;
         if (m_cfg_set) m_cfg = 1'b1;
         else if (clr) m_cfg = 1'b0;
      end
   end

   // Per-cycle comparison against the model, 1 time unit after the edge.
   always @(posedge clk) begin
      #1;
      chk("busy",    {255'd0, busy},    {255'd0, (m_busy_left != 0)});
      chk("valid",   {255'd0, valid},   {255'd0, m_valid});
      chk("data",    data,              m_data);
      chk("overrun", {255'd0, overrun}, {255'd0, m_ovr});
      chk("cfg_err", {255'd0, cfg_err}, {255'd0, m_cfg});
`ifdef SERIAL_RX_CTRL_STATS_EN
      chk("frame_cnt", {240'd0, frame_cnt}, {240'd0, m_frames});
`endif
   end

   // ------------------------------------------------------------------
   // Stimulus: send one frame. lat = cycles from the accepting edge until busy
   // is seen low (0 for a rejected start), or the cycle reset was applied when
   // abort_at >= 0. poke issues extra starts mid-frame and in the capture cycle.
   // ------------------------------------------------------------------
   task automatic run_frame(input logic [255:0] w, input int nb, input logic [31:0] p0,
                            input logic [31:0] p1, input int abort_at, input bit poke,
                            output int lat);
      longint nbe, n0e, n1e, ce, c;
      int     bi;
      nbe = (nb == 0) ? 1 : nb;
      n0e = (p0 == 0) ? 1 : longint'(p0);
      n1e = (p1 == 0) ? 1 : longint'(p1);
      ce  = n0e + nbe * n1e;
      tx_word = w;
      nbits   = nb[7:0];
      n0      = p0;
      n1      = p1;
      lat     = -1;
      @(negedge clk);
      start = 1'b1;
      for (int k = 0; k < 4000; k++) begin
         @(negedge clk);
         start = (poke && (k == 5 || longint'(k) == ce + 2)) ? 1'b1 : 1'b0;
         c = longint'(k) - 1;
         if (c >= n0e && c < n0e + nbe * n1e) begin
            bi = int'((c - n0e) / n1e);
            a  = w[int'(nbe) - 1 - bi];
         end else begin
            a = 1'b1;
         end
         if (abort_at >= 0 && k == abort_at + 1) begin
            rst_n = 1'b0;
            lat   = k;
            break;
         end
         if (!busy) begin
            lat = k;
            break;
         end
      end
      start = 1'b0;
      chk("frame_done", {255'd0, (lat >= 0)}, 256'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1, "watchdog");
   end

   int lat;

   initial begin
      rst_n   = 1'b0;
      start   = 1'b0;
      nbits   = 8'd0;
      n0      = '0;
      n1      = '0;
      a       = 1'b1;
      ready   = 1'b1;
      clr     = 1'b0;
      tx_word = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy",    {255'd0, busy},    256'd0);
      chk("rst_valid",   {255'd0, valid},   256'd0);
      chk("rst_data",    data,              256'd0);
      chk("rst_overrun", {255'd0, overrun}, 256'd0);
      chk("rst_cfg_err", {255'd0, cfg_err}, 256'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 0xA5, 8 bits, lead-in 4, 3 cycles/bit: end=28, capture at cnt 29.
      run_frame(256'hA5, 8, 32'd4, 32'd3, -1, 1'b0, lat);
      chk("a5_latency", 256'(lat), 256'd31);
      chk("a5_data",    data, 256'hA5);
      chk("a5_valid",   {255'd0, valid}, 256'd1);
      chk("a5_busy",    {255'd0, busy},  256'd0);
      @(negedge clk);

      // Two frames with no consumer: second one overruns and is dropped.
      ready = 1'b0;
      run_frame(256'h3C, 8, 32'd2, 32'd2, -1, 1'b0, lat);
      chk("3c_latency", 256'(lat), 256'd21);
      run_frame(256'h81, 8, 32'd2, 32'd2, -1, 1'b1, lat);
      chk("ovr_data",    data, 256'h3C);
      chk("ovr_overrun", {255'd0, overrun}, 256'd1);
      chk("ovr_valid",   {255'd0, valid},   256'd1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr_overrun", {255'd0, overrun}, 256'd0);
      chk("clr_valid",   {255'd0, valid},   256'd1);
      ready = 1'b1;
      @(negedge clk);
      chk("consume_valid", {255'd0, valid}, 256'd0);
      chk("consume_data",  data, 256'h3C);

      // All-zero parameters behave as 1/1/1: end=2, capture at cnt 3.
      run_frame(256'h1, 0, 32'd0, 32'd0, -1, 1'b0, lat);
      chk("min_latency", 256'(lat), 256'd5);
      chk("min_data",    data, 256'h1);
      @(negedge clk);

      // Frame length overflowing the counter is rejected.
      run_frame(256'h0, 32, 32'hFFFF_FFF0, 32'd1, -1, 1'b0, lat);
      chk("cfg_latency", 256'(lat), 256'd0);
      chk("cfg_err_set", {255'd0, cfg_err}, 256'd1);
      chk("cfg_busy",    {255'd0, busy},    256'd0);
      clr = 1'b1;
      @(negedge clk);
      chk("cfg_err_clr", {255'd0, cfg_err}, 256'd0);
      // Rejection (end = 2^32-1) in the same cycle as clr: the set wins.
      run_frame(256'h0, 32, 32'hFFFF_FFDF, 32'd1, -1, 1'b0, lat);
      clr = 1'b0;
      chk("cfg_set_wins", {255'd0, cfg_err}, 256'd1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;

      // Leave a word pending, then start the largest legal frame (end = 2^32-2)
      // and abort it with reset.
      ready = 1'b0;
      run_frame(256'h5A, 8, 32'd1, 32'd1, -1, 1'b0, lat);
      chk("5a_data", data, 256'h5A);
      run_frame(256'h0, 32, 32'hFFFF_FFDE, 32'd1, 3, 1'b0, lat);
      chk("max_accept_lat", 256'(lat), 256'd4);
      #1;
      chk("abort1_busy",  {255'd0, busy},  256'd0);
      chk("abort1_valid", {255'd0, valid}, 256'd0);
      chk("abort1_data",  data, 256'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ready = 1'b1;
      @(negedge clk);

      // 16-bit frame aborted by reset at cnt 10, then 0xBEEF received cleanly.
      run_frame(256'h1234, 16, 32'd3, 32'd2, 10, 1'b0, lat);
      #1;
      chk("abort2_busy",    {255'd0, busy},    256'd0);
      chk("abort2_valid",   {255'd0, valid},   256'd0);
      chk("abort2_data",    data,              256'd0);
      chk("abort2_overrun", {255'd0, overrun}, 256'd0);
      chk("abort2_cfg_err", {255'd0, cfg_err}, 256'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_frame(256'hBEEF, 16, 32'd2, 32'd3, -1, 1'b1, lat);
      chk("beef_latency", 256'(lat), 256'd53);
      chk("beef_data",    data, 256'hBEEF);
      chk("beef_valid",   {255'd0, valid}, 256'd1);
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
